voice_mix_scheduler: RTL and testbench

//  Once per audio frame, time-multiplexes one shared wave generator (phase in -> 16-bit sample out)

---
 rtl/voice_mix_scheduler_pkg.sv | 25 ++
 rtl/voice_mix_scheduler_if.sv | 25 ++
 rtl/voice_mix_scheduler_phase_bank.sv | 37 +++
 rtl/voice_mix_scheduler.sv | 130 +++++++++++++
 tb/tb_voice_mix_scheduler.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_mix_scheduler_pkg.sv
// Shared audio definitions for the voice mix scheduler: sample limits, FSM encoding and saturation.
package voice_mix_scheduler_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mix_state_e;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return SAMPLE_MAX;
        end else if (v < -32'sd32768) begin
            return SAMPLE_MIN;
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/voice_mix_scheduler_if.sv
// Request/response link between the scheduler and the shared wave generator.
interface voice_mix_scheduler_if #(
    parameter int ADDR_W = 10
) ();
    import voice_mix_scheduler_pkg::*;

    logic                       gen_req;
    logic [ADDR_W-1:0]          gen_addr;
    logic                       gen_ack;
    logic signed [SAMPLE_W-1:0] gen_sample;

    modport master (
        output gen_req,
        output gen_addr,
        input  gen_ack,
        input  gen_sample
    );

    modport slave (
        input  gen_req,
        input  gen_addr,
        output gen_ack,
        output gen_sample
    );
endinterface

// File: rtl/voice_mix_scheduler_phase_bank.sv
// Per-voice phase accumulators with one indexed address read and one add/clear write port.
module voice_phase_bank #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 22,
    parameter int ADDR_W     = 10,
    parameter int IDX_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic               wr_en_i,
    input  logic               wr_clr_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [PHASE_W-1:0] wr_step_i
);

    logic [PHASE_W-1:0] phase_q [NUM_VOICES];

    assign rd_addr_o = phase_q[rd_idx_i][PHASE_W-1 -: ADDR_W];

    // Addition wraps modulo 2^PHASE_W, which is the intended oscillator behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            if (wr_clr_i) begin
                phase_q[wr_idx_i] <= '0;
            end else begin
                phase_q[wr_idx_i] <= phase_q[wr_idx_i] + wr_step_i;
            end
        end
    end

endmodule

// File: rtl/voice_mix_scheduler.sv
// Time-multiplexes one shared wave generator across NUM_VOICES voices and mixes one
// saturated sample per audio frame.
module voice_mix_scheduler
    import voice_mix_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 22,
    parameter int ADDR_W     = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_frame,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0] voice_step,
    voice_mix_scheduler_if.master         gen,
    output logic signed [SAMPLE_W-1:0]    mix_sample,
    output logic                          mix_valid,
    output logic                          overrun
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);

    mix_state_e                 state_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       gen_req_q;
    logic [ADDR_W-1:0]          gen_addr_q;
    logic signed [SAMPLE_W-1:0] mix_sample_q;
    logic                       mix_valid_q;
    logic                       overrun_q;

    logic                       last_voice;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       wr_en;
    logic                       wr_clr;
    logic [PHASE_W-1:0]         step_sel;
    logic signed [ACC_W-1:0]    sample_ext;

    assign last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));
    assign step_sel   = voice_step[int'(idx_q)*PHASE_W +: PHASE_W];
    assign sample_ext = {{(ACC_W-SAMPLE_W){gen.gen_sample[SAMPLE_W-1]}}, gen.gen_sample};

    // A disabled slot clears its phase; an acked slot advances by the step live at ack time.
    assign wr_en  = ((state_q == ST_SCAN) && !voice_en[idx_q]) ||
                    ((state_q == ST_WAIT) && gen.gen_ack);
    assign wr_clr = (state_q == ST_SCAN);

    voice_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (idx_q),
        .rd_addr_o  (rd_addr),
        .wr_en_i    (wr_en),
        .wr_clr_i   (wr_clr),
        .wr_idx_i   (idx_q),
        .wr_step_i  (step_sel)
    );

    // state   | meaning
    // IDLE    | waiting for new_frame
    // SCAN    | checking enable of voice idx, issuing request if enabled
    // WAIT    | request outstanding, holding gen_addr until gen_ack
    // DONE    | publishing saturated mix and pulsing mix_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            gen_req_q    <= 1'b0;
            gen_addr_q   <= '0;
            mix_sample_q <= '0;
            mix_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            overrun_q   <= new_frame && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (new_frame) begin
                        idx_q   <= '0;
                        acc_q   <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (voice_en[idx_q]) begin
                        gen_req_q  <= 1'b1;
                        gen_addr_q <= rd_addr;
                        state_q    <= ST_WAIT;
                    end else if (last_voice) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (gen.gen_ack) begin
                        acc_q     <= acc_q + sample_ext;
                        gen_req_q <= 1'b0;
                        if (last_voice) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    mix_sample_q <= sat16({{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q});
                    mix_valid_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gen.gen_req  = gen_req_q;
    assign gen.gen_addr = gen_addr_q;
    assign mix_sample   = mix_sample_q;
    assign mix_valid    = mix_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench for voice_mix_scheduler with a programmable-delay generator model.
module tb_voice_mix_scheduler;

    localparam int NV = 4;
    localparam int PW = 22;
    localparam int AW = 10;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   new_frame = 1'b0;
    logic [NV-1:0]          voice_en = '0;
    logic [NV*PW-1:0]       voice_step = '0;
    logic signed [15:0]     mix_sample;
    logic                   mix_valid;
    logic                   overrun;

    voice_mix_scheduler_if #(.ADDR_W(AW)) gen_if ();

    voice_mix_scheduler #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .new_frame  (new_frame),
        .voice_en   (voice_en),
        .voice_step (voice_step),
        .gen        (gen_if),
        .mix_sample (mix_sample),
        .mix_valid  (mix_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            base;
    } req_t;

    int         checks = 0;
    int         failures = 0;
    int         ack_delay = 0;
    int         wcnt = 0;
    int         req_cnt = 0;
    int         mix_cnt = 0;
    int         ovr_cnt = 0;
    req_t       req_q[$];
    int         mix_q[$];
    logic [PW-1:0] phase_m [NV];
    int         samp_tab [NV];

    initial begin
        gen_if.gen_ack = 1'b0;
        gen_if.gen_sample = '0;
    end

    // Generator model: acks ack_delay cycles after gen_req rises, sample = base + gen_addr.
    always @(negedge clk) begin
        req_t r;
        if (!reset) begin
            gen_if.gen_ack = 1'b0;
            wcnt = 0;
        end else if (gen_if.gen_ack) begin
            gen_if.gen_ack = 1'b0;
        end else if (gen_if.gen_req) begin
            if (wcnt >= ack_delay) begin
                checks++;
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL gen_unexpected_req addr=%0d", gen_if.gen_addr);
                    gen_if.gen_sample = '0;
                end else begin
                    r = req_q.pop_front();
                    if (gen_if.gen_addr !== r.addr) begin
                        failures++;
                        $display("FAIL gen_addr got=%0d exp=%0d", gen_if.gen_addr, r.addr);
                    end
                    gen_if.gen_sample = 16'(r.base + int'(gen_if.gen_addr));
                end
                gen_if.gen_ack = 1'b1;
                wcnt = 0;
                req_cnt++;
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        int e;
        logic signed [15:0] e16;
        if (reset) begin
            if (overrun === 1'b1) ovr_cnt++;
            if (mix_valid === 1'b1) begin
                mix_cnt++;
                checks++;
                if (mix_q.size() == 0) begin
                    failures++;
                    $display("FAIL mix_unexpected got=%0d", mix_sample);
                end else begin
                    e = mix_q.pop_front();
                    e16 = 16'(e);
                    if (mix_sample !== e16) begin
                        failures++;
                        $display("FAIL mix_sample got=%0d exp=%0d", mix_sample, e16);
                    end
                end
            end
        end
    end

    task automatic set_step(input int v, input logic [PW-1:0] val);
        voice_step[v*PW +: PW] = val;
    endtask

    task automatic model_frame();
        int sum = 0;
        req_t r;
        for (int v = 0; v < NV; v++) begin
            if (voice_en[v]) begin
                r.addr = phase_m[v][PW-1 -: AW];
                r.base = samp_tab[v];
                req_q.push_back(r);
                sum += samp_tab[v] + int'(r.addr);
                phase_m[v] = phase_m[v] + voice_step[v*PW +: PW];
            end else begin
                phase_m[v] = '0;
            end
        end
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
        mix_q.push_back(sum);
    endtask

    task automatic clear_model();
        req_q.delete();
        mix_q.delete();
        for (int v = 0; v < NV; v++) phase_m[v] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        new_frame = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit accept);
        @(posedge clk);
        #1 new_frame = 1'b1;
        if (accept) model_frame();
        @(posedge clk);
        #1 new_frame = 1'b0;
    endtask

    task automatic wait_mix(input string name, input int start, input int limit);
        int n = 0;
        while (mix_cnt == start && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (mix_cnt == start) begin
            failures++;
            $display("FAIL %s timeout got=no_mix_valid exp=mix_valid within %0d cycles", name, limit);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (req_q.size() != 0 || mix_q.size() != 0) begin
            failures++;
            $display("FAIL %s drained got=req%0d/mix%0d exp=0/0", name, req_q.size(), mix_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (gen_if.gen_req !== 1'b0 || gen_if.gen_addr !== '0) begin
            failures++;
            $display("FAIL reset_gen got=%b/%0d exp=0/0", gen_if.gen_req, gen_if.gen_addr);
        end
        checks++;
        if (mix_sample !== 16'sd0 || mix_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%0d/%b/%b exp=0/0/0", mix_sample, mix_valid, overrun);
        end
        do_reset();
    endtask

    task automatic test_basic_mix();
        int cyc;
        int r0 = req_cnt;
        samp_tab = '{1000, 2000, -500, 300};
        voice_en = 4'b1111;
        voice_step = '0;
        ack_delay = 0;
        @(posedge clk);
        #1 new_frame = 1'b1;
        model_frame();
        @(posedge clk);
        #1 new_frame = 1'b0;
        cyc = 1;
        while (mix_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 10) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=10", cyc);
        end
        checks++;
        if (mix_sample !== 16'sd2800) begin
            failures++;
            $display("FAIL basic_value got=%0d exp=2800", mix_sample);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_cnt - r0 != 4) begin
            failures++;
            $display("FAIL basic_req_count got=%0d exp=4", req_cnt - r0);
        end
        check_drained("basic");
    endtask

    task automatic test_saturation();
        int m0;
        samp_tab = '{16000, 16000, 16000, 16000};
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("sat_pos", m0, 60);
        checks++;
        if (mix_sample !== 16'sh7FFF) begin
            failures++;
            $display("FAIL sat_pos got=%0d exp=32767", mix_sample);
        end
        samp_tab = '{-16000, -16000, -16000, -16000};
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("sat_neg", m0, 60);
        checks++;
        if (mix_sample !== 16'sh8000) begin
            failures++;
            $display("FAIL sat_neg got=%0d exp=-32768", mix_sample);
        end
        check_drained("sat");
    endtask

    task automatic test_partial_enable();
        int m0;
        int r0;
        do_reset();
        samp_tab = '{10, 20, 30, 40};
        voice_en = 4'b1111;
        voice_step = '0;
        set_step(1, 22'(5 << 12));
        set_step(3, 22'(9 << 12));
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("partial_pre", m0, 60);
        voice_en = 4'b0101;
        for (int v = 0; v < NV; v++) set_step(v, 22'(1 << 12));
        for (int f = 0; f < 3; f++) begin
            r0 = req_cnt;
            m0 = mix_cnt;
            send_frame(1'b1);
            wait_mix("partial", m0, 60);
            checks++;
            if (req_cnt - r0 != 2) begin
                failures++;
                $display("FAIL partial_req_count got=%0d exp=2", req_cnt - r0);
            end
        end
        voice_en = 4'b1111;
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("partial_reenable", m0, 60);
        check_drained("partial");
    endtask

    task automatic test_overrun();
        int m0 = mix_cnt;
        int o0 = ovr_cnt;
        do_reset();
        samp_tab = '{-7, 11, 13, 17};
        voice_en = 4'b1111;
        voice_step = '0;
        ack_delay = 5;
        @(posedge clk);
        #1 new_frame = 1'b1;
        model_frame();
        @(posedge clk);
        #1 new_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1 new_frame = 1'b1;
        @(posedge clk);
        #1 new_frame = 1'b0;
        wait_mix("overrun_pass", m0, 100);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (ovr_cnt - o0 != 1) begin
            failures++;
            $display("FAIL overrun_count got=%0d exp=1", ovr_cnt - o0);
        end
        checks++;
        if (mix_cnt - m0 != 1) begin
            failures++;
            $display("FAIL overrun_mix_count got=%0d exp=1", mix_cnt - m0);
        end
        ack_delay = 0;
        check_drained("overrun");
    endtask

    task automatic test_phase_wrap();
        int m0;
        do_reset();
        samp_tab = '{100, 0, 0, 0};
        voice_en = 4'b0001;
        voice_step = '0;
        set_step(0, 22'h3FFFFF);
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("wrap_1", m0, 60);
        set_step(0, 22'd2);
        for (int f = 0; f < 2; f++) begin
            m0 = mix_cnt;
            send_frame(1'b1);
            wait_mix("wrap_n", m0, 60);
        end
        checks++;
        if (mix_sample !== 16'sd100) begin
            failures++;
            $display("FAIL wrap_addr_zero got=%0d exp=100", mix_sample);
        end
        check_drained("wrap");
    endtask

    task automatic test_reset_in_wait();
        int m0;
        int n = 0;
        do_reset();
        samp_tab = '{1, 2, 3, 4};
        voice_en = 4'b1111;
        for (int v = 0; v < NV; v++) set_step(v, 22'(3 << 12));
        ack_delay = 0;
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("rst_pre", m0, 60);
        ack_delay = 20;
        send_frame(1'b1);
        while (gen_if.gen_req !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (gen_if.gen_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_req got=%b exp=1", gen_if.gen_req);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (gen_if.gen_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_req_drop got=%b exp=0", gen_if.gen_req);
        end
        clear_model();
        m0 = mix_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (mix_cnt != m0) begin
            failures++;
            $display("FAIL rst_no_mix got=%0d exp=%0d", mix_cnt, m0);
        end
        ack_delay = 0;
        m0 = mix_cnt;
        send_frame(1'b1);
        wait_mix("rst_clean", m0, 60);
        checks++;
        if (mix_sample !== 16'sd10) begin
            failures++;
            $display("FAIL rst_clean_value got=%0d exp=10", mix_sample);
        end
        check_drained("rst_wait");
    endtask

    task automatic test_all_disabled();
        int cyc;
        int r0 = req_cnt;
        voice_en = 4'b0000;
        @(posedge clk);
        #1 new_frame = 1'b1;
        model_frame();
        @(posedge clk);
        #1 new_frame = 1'b0;
        cyc = 1;
        while (mix_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != NV + 2) begin
            failures++;
            $display("FAIL disabled_latency got=%0d exp=%0d", cyc, NV + 2);
        end
        checks++;
        if (req_cnt != r0 || mix_sample !== 16'sd0) begin
            failures++;
            $display("FAIL disabled_out got=req%0d/%0d exp=req0/0", req_cnt - r0, mix_sample);
        end
        repeat (2) @(posedge clk);
        #1;
        check_drained("disabled");
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            phase_m[v] = '0;
            samp_tab[v] = 0;
        end
        test_reset();
        test_basic_mix();
        test_saturation();
        test_partial_enable();
        test_overrun();
        test_phase_wrap();
        test_reset_in_wait();
        test_all_disabled();
        checks++;
        if (ovr_cnt != 1) begin
            failures++;
            $display("FAIL overrun_total got=%0d exp=1", ovr_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
